// File: rtl/one_hot_row_scanner.sv
// one_hot_row_scanner: autonomous one-hot LED-matrix row scanner with per-row dwell, direction, direct load and frame pulse.
// Define ONE_HOT_ROW_SCANNER_BLANKING_EN to insert BLANK_CYCLES dark cycles between rows for anti-ghosting.
module one_hot_row_scanner #(
    parameter int SEL_WIDTH      = 3,
    parameter int OUT_WIDTH      = 8,
    parameter int DWELL_WIDTH    = 16,
    parameter bit ACTIVE_LOW_OUT = 1'b0,
    parameter int BLANK_CYCLES   = 4
) (
    input  logic                   ROWSCAN_CLOCK_50,
    input  logic                   ROWSCAN_RESET_InLow,
    input  logic                   ROWSCAN_Enable_In,
    input  logic                   ROWSCAN_Dir_In,
    input  logic [DWELL_WIDTH-1:0] ROWSCAN_Dwell_In,
    input  logic                   ROWSCAN_Load_In,
    input  logic [SEL_WIDTH-1:0]   ROWSCAN_LoadRow_In,
    output logic [OUT_WIDTH-1:0]   ROWSCAN_Data_Out,
    output logic [SEL_WIDTH-1:0]   ROWSCAN_Row_Out,
    output logic                   ROWSCAN_Frame_Out
);

`ifdef ONE_HOT_ROW_SCANNER_BLANKING_EN
    localparam bit BLANK_EN = (BLANK_CYCLES > 0);
    localparam int BW       = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
`endif

    localparam logic [SEL_WIDTH-1:0] ROW_MAX   = SEL_WIDTH'(OUT_WIDTH - 1);
    localparam logic [SEL_WIDTH:0]   ROW_LIMIT = (SEL_WIDTH + 1)'(OUT_WIDTH);
    localparam logic [OUT_WIDTH-1:0] INACTIVE  = {OUT_WIDTH{ACTIVE_LOW_OUT}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1
`ifdef ONE_HOT_ROW_SCANNER_BLANKING_EN
        , BLANK = 2'd2
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   row_q, row_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   frame_q, frame_d;
    logic                   start_d;
`ifdef ONE_HOT_ROW_SCANNER_BLANKING_EN
    logic [BW-1:0]          blank_q, blank_d;
`endif

    logic                 load_ok;
    logic [SEL_WIDTH-1:0] next_row;
    logic [SEL_WIDTH-1:0] frame_row;

    assign load_ok   = ROWSCAN_Load_In && ({1'b0, ROWSCAN_LoadRow_In} < ROW_LIMIT);
    assign frame_row = ROWSCAN_Dir_In ? ROW_MAX : '0;
    assign next_row  = ROWSCAN_Dir_In ? ((row_q == '0)      ? ROW_MAX : row_q - 1'b1)
                                      : ((row_q == ROW_MAX) ? '0      : row_q + 1'b1);

    // NOTE: every register, outputs included, is cleared asynchronously so outputs go inactive the instant reset asserts.
    always_ff @(posedge ROWSCAN_CLOCK_50 or negedge ROWSCAN_RESET_InLow) begin
        if (!ROWSCAN_RESET_InLow) begin
            state_q <= IDLE;
            row_q   <= '0;
            dwell_q <= '0;
            data_q  <= INACTIVE;
            frame_q <= 1'b0;
`ifdef ONE_HOT_ROW_SCANNER_BLANKING_EN
            blank_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            data_q  <= data_d;
            frame_q <= frame_d;
`ifdef ONE_HOT_ROW_SCANNER_BLANKING_EN
            blank_q <= blank_d;
`endif
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no inferred latches).
        state_d = state_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        start_d = 1'b0;
`ifdef ONE_HOT_ROW_SCANNER_BLANKING_EN
        blank_d = blank_q;
`endif
        if (state_q == IDLE) begin
            if (load_ok) begin
                row_d = ROWSCAN_LoadRow_In;
            end else if (ROWSCAN_Enable_In) begin
                state_d = SHOW;
                dwell_d = ROWSCAN_Dwell_In;
                start_d = 1'b1;
            end
        end else if (!ROWSCAN_Enable_In) begin
            state_d = IDLE;
            if (load_ok) row_d = ROWSCAN_LoadRow_In;
        end else if (load_ok) begin
            // Load beats a natural advance and also cuts any blanking short.
            state_d = SHOW;
            row_d   = ROWSCAN_LoadRow_In;
            dwell_d = ROWSCAN_Dwell_In;
            start_d = 1'b1;
        end else if (state_q == SHOW) begin
            if (dwell_q == '0) begin
                row_d = next_row;
`ifdef ONE_HOT_ROW_SCANNER_BLANKING_EN
                if (BLANK_EN) begin
                    state_d = BLANK;
                    blank_d = BW'(BLANK_CYCLES - 1);
                end else begin
                    dwell_d = ROWSCAN_Dwell_In;
                    start_d = 1'b1;
                end
`else
                dwell_d = ROWSCAN_Dwell_In;
                start_d = 1'b1;
`endif
            end else begin
                dwell_d = dwell_q - 1'b1;
            end
        end
`ifdef ONE_HOT_ROW_SCANNER_BLANKING_EN
        else begin
            if (blank_q == '0) begin
                state_d = SHOW;
                dwell_d = ROWSCAN_Dwell_In;
                start_d = 1'b1;
            end else begin
                blank_d = blank_q - 1'b1;
            end
        end
`endif
    end

    // Outputs are decoded from the next state and registered, so the pins never glitch.
    always_comb begin
        data_d = INACTIVE;
        if (state_d == SHOW) begin
            data_d = {{(OUT_WIDTH-1){1'b0}}, 1'b1} << row_d;
            if (ACTIVE_LOW_OUT) data_d = ~data_d;
        end
        frame_d = start_d && (row_d == frame_row);
    end

    assign ROWSCAN_Data_Out  = data_q;
    assign ROWSCAN_Row_Out   = row_q;
    assign ROWSCAN_Frame_Out = frame_q;

endmodule

// File: tb/tb_one_hot_row_scanner.sv
// tb_one_hot_row_scanner: scoreboard bench for one_hot_row_scanner; an 8-row active-high instance and a
// 5-row (SEL_WIDTH 4) active-low instance run side by side against a cycle model.
module tb_one_hot_row_scanner;

    localparam int TB_BLANK = 4;
`ifdef ONE_HOT_ROW_SCANNER_BLANKING_EN
    localparam bit BLK = (TB_BLANK > 0);
`else
    localparam bit BLK = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        dir   = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] dwell = '0;
    logic [2:0]  lr8   = '0;
    logic [3:0]  lr5   = '0;

    logic [7:0] data8;
    logic [2:0] row8;
    logic       fr8;
    logic [4:0] data5;
    logic [3:0] row5;
    logic       fr5;

    always #5 clk = ~clk;

    one_hot_row_scanner #(
        .SEL_WIDTH(3), .OUT_WIDTH(8), .DWELL_WIDTH(16), .ACTIVE_LOW_OUT(1'b0), .BLANK_CYCLES(TB_BLANK)
    ) u_dut8 (
        .ROWSCAN_CLOCK_50   (clk),
        .ROWSCAN_RESET_InLow(rst_n),
        .ROWSCAN_Enable_In  (en),
        .ROWSCAN_Dir_In     (dir),
        .ROWSCAN_Dwell_In   (dwell),
        .ROWSCAN_Load_In    (load),
        .ROWSCAN_LoadRow_In (lr8),
        .ROWSCAN_Data_Out   (data8),
        .ROWSCAN_Row_Out    (row8),
        .ROWSCAN_Frame_Out  (fr8)
    );

    one_hot_row_scanner #(
        .SEL_WIDTH(4), .OUT_WIDTH(5), .DWELL_WIDTH(16), .ACTIVE_LOW_OUT(1'b1), .BLANK_CYCLES(TB_BLANK)
    ) u_dut5 (
        .ROWSCAN_CLOCK_50   (clk),
        .ROWSCAN_RESET_InLow(rst_n),
        .ROWSCAN_Enable_In  (en),
        .ROWSCAN_Dir_In     (dir),
        .ROWSCAN_Dwell_In   (dwell),
        .ROWSCAN_Load_In    (load),
        .ROWSCAN_LoadRow_In (lr5),
        .ROWSCAN_Data_Out   (data5),
        .ROWSCAN_Row_Out    (row5),
        .ROWSCAN_Frame_Out  (fr5)
    );

    typedef enum int {M_IDLE, M_SHOW, M_BLANK} mst_e;
    typedef struct {
        mst_e st;
        int   row;
        int   left;   // cycles remaining after the current one in this row/blank period
        bit   frame;
    } model_t;
    typedef struct {
        logic [7:0] d8;
        logic [2:0] r8;
        logic       f8;
        logic [4:0] d5;
        logic [3:0] r5;
        logic       f5;
    } exp_t;

    exp_t   sb[$];
    model_t m8, m5;
    int     n_vec = 0;
    int     n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.st = M_IDLE; m.row = 0; m.left = 0; m.frame = 1'b0;
        return m;
    endfunction

    // One clock of the reference behaviour for an ow-row scanner.
    function automatic model_t step(model_t m, bit e, bit d, int dw, bit l, int lr, int ow);
        model_t n;
        bit ld_ok;
        int fs, nxt;
        n = m;
        n.frame = 1'b0;
        ld_ok = l && (lr < ow);
        fs  = d ? ow - 1 : 0;
        nxt = d ? (m.row + ow - 1) % ow : (m.row + 1) % ow;
        if (m.st == M_IDLE) begin
            if (ld_ok) n.row = lr;
            else if (e) begin
                n.st = M_SHOW; n.left = dw; n.frame = (m.row == fs);
            end
        end else if (!e) begin
            n.st = M_IDLE;
            if (ld_ok) n.row = lr;
        end else if (ld_ok) begin
            n.st = M_SHOW; n.row = lr; n.left = dw; n.frame = (lr == fs);
        end else if (m.st == M_SHOW) begin
            if (m.left > 0) n.left = m.left - 1;
            else begin
                n.row = nxt;
                if (BLK) begin
                    n.st = M_BLANK; n.left = TB_BLANK - 1;
                end else begin
                    n.left = dw; n.frame = (nxt == fs);
                end
            end
        end else begin
            if (m.left > 0) n.left = m.left - 1;
            else begin
                n.st = M_SHOW; n.left = dw; n.frame = (m.row == fs);
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] pins(model_t m, int ow, bit inv);
        logic [7:0] v;
        logic [7:0] mask;
        v = '0;
        if (m.st == M_SHOW) v[m.row] = 1'b1;
        if (inv) v = ~v;
        mask = 8'((1 << ow) - 1);
        return v & mask;
    endfunction

    task automatic cycle(input bit e, input bit d, input int dw, input bit l, input int l8, input int l5);
        exp_t x;
        exp_t got;
        @(negedge clk);
        en = e; dir = d; dwell = 16'(dw); load = l; lr8 = 3'(l8); lr5 = 4'(l5);
        m8 = step(m8, e, d, dw, l, l8, 8);
        m5 = step(m5, e, d, dw, l, l5, 5);
        x.d8 = pins(m8, 8, 1'b0);
        x.r8 = 3'(m8.row);
        x.f8 = m8.frame;
        x.d5 = 5'(pins(m5, 5, 1'b1));
        x.r5 = 4'(m5.row);
        x.f5 = m5.frame;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("data8", 32'(data8), 32'(got.d8));
        check("row8",  32'(row8),  32'(got.r8));
        check("frame8", 32'(fr8),  32'(got.f8));
        check("data5", 32'(data5), 32'(got.d5));
        check("row5",  32'(row5),  32'(got.r5));
        check("frame5", 32'(fr5),  32'(got.f5));
        check("onehot8", 32'($countones(data8) <= 1), 32'd1);
        check("onehot5", 32'($countones(~data5) <= 1), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data8"}, 32'(data8), 32'h00);
        check({tag, "_row8"},  32'(row8),  32'h0);
        check({tag, "_fr8"},   32'(fr8),   32'h0);
        check({tag, "_data5"}, 32'(data5), 32'h1f);
        check({tag, "_row5"},  32'(row5),  32'h0);
        check({tag, "_fr5"},   32'(fr5),   32'h0);
    endtask

    initial begin
        m8 = model_reset();
        m5 = model_reset();
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Forward scan, dwell 2: 24-cycle frame, twice.
        for (int i = 0; i < 50; i++) cycle(1, 0, 2, 0, 0, 0);
        // Reverse scan, dwell 0: one row per cycle.
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 0, 0);
        // Load mid-row, then invalid load for the 5-row instance.
        for (int i = 0; i < 3; i++) cycle(1, 0, 3, 0, 0, 0);
        cycle(1, 0, 3, 1, 5, 3);
        for (int i = 0; i < 6; i++) cycle(1, 0, 3, 0, 0, 0);
        cycle(1, 0, 3, 1, 7, 9);
        for (int i = 0; i < 6; i++) cycle(1, 0, 3, 0, 0, 0);
        // Load of the frame-start row pulses the frame output.
        cycle(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 0, 0);
        // Enable drop, load while idle, re-enable.
        for (int i = 0; i < 3; i++) cycle(0, 0, 2, 0, 0, 0);
        cycle(0, 0, 2, 1, 3, 4);
        cycle(0, 0, 2, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 2, 0, 0, 0);
        // Randomised mix: direction/dwell changes mid-row, rare loads and enable drops.
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 7), $urandom_range(0, 15));

        // Asynchronous reset mid-dwell.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        en = 1'b0; load = 1'b0;
        m8 = model_reset();
        m5 = model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) cycle(1, 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
